inst_mem_ctrl: RTL and testbench

- Parametrised, writable instruction memory for the single-cycle/multi-cycle CPU fetch path.
- Replaces the fixed combinational ROM with:
  - a synchronous word array;
  - a registered fetch request/response handshake with backpressure;
  - a loader write port;
  - a reset-time clear sequence;
  - alignment and range fault reporting.
- Sits between the PC/fetch stage and the decode stage; the loader port is driven by the testbench or a boot unit.

---
 rtl/inst_mem_ctrl.sv | 137 +++++++++++++
 tb/tb_inst_mem_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_ctrl.sv
// Writable instruction memory for the CPU fetch path: registered fetch response with
// backpressure, loader write port, post-reset clear sequence and alignment/range faults.
module inst_mem_ctrl #(
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       DEPTH          = 64,
  parameter int unsigned       IDX_W          = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] NOP_WORD       = '0,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              fetch_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic              rsp_fault_align,
  output logic              rsp_fault_range,
  input  logic              ld_we,
  input  logic [IDX_W-1:0]  ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              init_done
);

  localparam int unsigned       AL      = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] DepthA  = ADDR_W'(DEPTH);
  localparam logic [IDX_W:0]    DepthI  = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LastIdx = IDX_W'(DEPTH - 1);

  typedef enum logic {StInit, StReady} state_e;
  localparam state_e StReset = CLEAR_ON_RESET ? StInit : StReady;

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              init_done_q, init_done_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_instr_q, rsp_instr_d;
  logic              fault_align_q, fault_align_d;
  logic              fault_range_q, fault_range_d;

  logic [ADDR_W-1:0] fetch_idx;
  logic              fault_align, fault_range, accept;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Index kept at full PC width so high PC bits still trip the range fault.
  assign fetch_idx   = fetch_pc >> AL;
  assign fault_align = |fetch_pc[AL-1:0];
  assign fault_range = fetch_idx >= DepthA;

  // init_done_q doubles as the READY qualifier so every handshake is low during reset.
  assign ld_ready    = init_done_q;
  assign fetch_ready = init_done_q && !ld_we && (!rsp_valid_q || rsp_ready);
  assign accept      = fetch_req && fetch_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    mem_we      = 1'b0;
    mem_waddr   = ld_addr;
    mem_wdata   = ld_data;
    unique case (state_q)
      StInit: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = NOP_WORD;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LastIdx) begin
          state_d     = StReady;
          init_done_d = 1'b1;
          cnt_d       = '0;
        end
      end
      StReady: begin
        init_done_d = 1'b1;
        // Out-of-range loader writes are dropped.
        mem_we      = init_done_q && ld_we && ({1'b0, ld_addr} < DepthI);
      end
    endcase
  end

  always_comb begin
    rsp_valid_d   = rsp_valid_q;
    rsp_instr_d   = rsp_instr_q;
    fault_align_d = fault_align_q;
    fault_range_d = fault_range_q;
    if (accept) begin
      rsp_valid_d   = 1'b1;
      fault_align_d = fault_align;
      fault_range_d = fault_range;
      rsp_instr_d   = (fault_align || fault_range) ? NOP_WORD
                                                    : mem_q[fetch_idx[IDX_W-1:0]];
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StReset;
      cnt_q         <= '0;
      init_done_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_instr_q   <= '0;
      fault_align_q <= 1'b0;
      fault_range_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      init_done_q   <= init_done_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_instr_q   <= rsp_instr_d;
      fault_align_q <= fault_align_d;
      fault_range_q <= fault_range_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign rsp_valid       = rsp_valid_q;
  assign rsp_instr       = rsp_instr_q;
  assign rsp_fault_align = fault_align_q;
  assign rsp_fault_range = fault_range_q;
  assign init_done       = init_done_q;

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Self-checking bench for inst_mem_ctrl: directed tables, reset/backpressure sequences and
// a randomized phase against a behavioural memory model.
module tb_inst_mem_ctrl;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned IDX_W  = 4;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              fetch_req = 1'b0;
  logic [ADDR_W-1:0] fetch_pc = '0;
  logic              fetch_ready;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_instr;
  logic              rsp_fault_align;
  logic              rsp_fault_range;
  logic              ld_we = 1'b0;
  logic [IDX_W-1:0]  ld_addr = '0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              ld_ready;
  logic              init_done;

  always #5 clk = ~clk;

  inst_mem_ctrl #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .DEPTH         (DEPTH),
    .NOP_WORD      (NOP),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_req      (fetch_req),
    .fetch_pc       (fetch_pc),
    .fetch_ready    (fetch_ready),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_instr      (rsp_instr),
    .rsp_fault_align(rsp_fault_align),
    .rsp_fault_range(rsp_fault_range),
    .ld_we          (ld_we),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data),
    .ld_ready       (ld_ready),
    .init_done      (init_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        flt_a;
    logic        flt_r;
  } vec_t;

  logic [31:0] prog [6];
  vec_t        vecs [8];
  logic [31:0] m_mem [DEPTH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    check({name, "_valid"}, rsp_valid, 0);
    check({name, "_instr"}, rsp_instr, 0);
    check({name, "_align"}, rsp_fault_align, 0);
    check({name, "_range"}, rsp_fault_range, 0);
    check({name, "_fetch_ready"}, fetch_ready, 0);
    check({name, "_ld_ready"}, ld_ready, 0);
    check({name, "_init_done"}, init_done, 0);
  endtask

  // Counts cycles from reset release until init_done; handshakes must stay low meanwhile.
  task automatic wait_init(input string name);
    int cyc = 0;
    while (!init_done && cyc < 40) begin
      if (fetch_ready !== 1'b0 || ld_ready !== 1'b0) begin
        check({name, "_ready_in_init"}, {fetch_ready, ld_ready}, 0);
      end
      tick();
      cyc++;
    end
    fetch_req = 1'b0;
    ld_we     = 1'b0;
    check({name, "_init_cycles"}, cyc, 16);
    check({name, "_no_rsp_after_init"}, rsp_valid, 0);
  endtask

  task automatic do_fetch(input string name, input logic [31:0] pc);
    fetch_req = 1'b1;
    fetch_pc  = pc;
    rsp_ready = 1'b1;
    #1;
    check({name, "_fetch_ready"}, fetch_ready, 1);
    tick();
    fetch_req = 1'b0;
    check({name, "_valid"}, rsp_valid, 1);
  endtask

  task automatic do_load(input logic [IDX_W-1:0] a, input logic [31:0] d);
    ld_we   = 1'b1;
    ld_addr = a;
    ld_data = d;
    #1;
    check("load_ld_ready", ld_ready, 1);
    tick();
    ld_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    prog[0] = 32'h8C03_0000; prog[1] = 32'hAC02_0000; prog[2] = 32'h1020_0003;
    prog[3] = 32'h0083_2020; prog[4] = 32'h0083_1025; prog[5] = 32'h0083_2822;
    vecs[0] = '{32'h0000_0006, NOP,          1'b1, 1'b0};
    vecs[1] = '{32'h0000_0040, NOP,          1'b0, 1'b1};
    vecs[2] = '{32'h0000_0042, NOP,          1'b1, 1'b1};
    vecs[3] = '{32'h0000_0014, 32'h0083_2822, 1'b0, 1'b0};
    vecs[4] = '{32'h0000_003C, NOP,          1'b0, 1'b0};
    vecs[5] = '{32'h1000_0004, NOP,          1'b0, 1'b1};
    vecs[6] = '{32'h0000_0024, NOP,          1'b0, 1'b0};
    vecs[7] = '{32'h0000_0001, NOP,          1'b1, 1'b0};

    // Reset state, then release with requests asserted; they must be ignored during the clear.
    tick();
    tick();
    check_zero("reset");
    fetch_req = 1'b1;
    fetch_pc  = 32'h0;
    ld_we     = 1'b1;
    ld_addr   = 4'd9;
    ld_data   = 32'h1234_5678;
    rst_n     = 1'b1;
    wait_init("init0");

    do_fetch("post_init_pc8", 32'h8);
    check("post_init_pc8_instr", rsp_instr, NOP);
    check("post_init_pc8_align", rsp_fault_align, 0);
    check("post_init_pc8_range", rsp_fault_range, 0);
    tick();
    check("post_init_drain", rsp_valid, 0);

    for (int i = 0; i < 6; i++) do_load(IDX_W'(i), prog[i]);

    // Back-to-back fetches, one response per cycle.
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      fetch_req = 1'b1;
      fetch_pc  = 32'(i * 4);
      #1;
      check("b2b_fetch_ready", fetch_ready, 1);
      tick();
      check("b2b_valid", rsp_valid, 1);
      check("b2b_instr", rsp_instr, prog[i]);
    end
    fetch_req = 1'b0;
    tick();
    check("b2b_drain", rsp_valid, 0);

    // Backpressure.
    rsp_ready = 1'b0;
    fetch_req = 1'b1;
    fetch_pc  = 32'h4;
    #1;
    check("bp_accept", fetch_ready, 1);
    tick();
    fetch_pc = 32'h8;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_stall_ready", fetch_ready, 0);
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_instr", rsp_instr, 32'hAC02_0000);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", fetch_ready, 1);
    tick();
    fetch_req = 1'b0;
    check("bp_next_instr", rsp_instr, 32'h1020_0003);
    tick();

    // Fault and content table.
    for (int i = 0; i < 8; i++) begin
      do_fetch("vec", vecs[i].pc);
      check("vec_instr", rsp_instr, vecs[i].instr);
      check("vec_align", rsp_fault_align, vecs[i].flt_a);
      check("vec_range", rsp_fault_range, vecs[i].flt_r);
    end
    tick();

    // Loader/fetch conflict: loader wins, fetch retried next cycle sees new data.
    ld_we     = 1'b1;
    ld_addr   = 4'd2;
    ld_data   = 32'hDEAD_BEEF;
    fetch_req = 1'b1;
    fetch_pc  = 32'h8;
    rsp_ready = 1'b1;
    #1;
    check("conflict_fetch_ready", fetch_ready, 0);
    check("conflict_ld_ready", ld_ready, 1);
    tick();
    ld_we = 1'b0;
    check("conflict_no_rsp", rsp_valid, 0);
    #1;
    check("retry_fetch_ready", fetch_ready, 1);
    tick();
    fetch_req = 1'b0;
    check("retry_valid", rsp_valid, 1);
    check("retry_instr", rsp_instr, 32'hDEAD_BEEF);
    tick();

    // Reset with a response pending.
    rsp_ready = 1'b0;
    fetch_req = 1'b1;
    fetch_pc  = 32'h4;
    tick();
    fetch_req = 1'b0;
    check("pend_valid", rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    check_zero("pend_reset");
    tick();
    rst_n = 1'b1;
    wait_init("init1");

    // Reset pulsed during INIT cycle 7.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    rst_n = 1'b0;
    #1;
    check_zero("mid_init_reset");
    tick();
    rst_n = 1'b1;
    wait_init("init2");
    do_fetch("after_clear_pc4", 32'h4);
    check("after_clear_instr", rsp_instr, NOP);
    tick();

    // Randomized phase against a behavioural model; memory is freshly cleared here.
    begin
      logic        m_valid;
      logic [31:0] m_instr;
      logic        m_fa, m_fr;
      logic        exp_fr;
      longint      idx;
      m_valid = 1'b0;
      m_instr = '0;
      m_fa    = 1'b0;
      m_fr    = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
      for (int c = 0; c < 500; c++) begin
        fetch_req = 1'($urandom_range(0, 1));
        fetch_pc  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 80));
        rsp_ready = ($urandom_range(0, 3) != 0);
        ld_we     = ($urandom_range(0, 3) == 0);
        ld_addr   = IDX_W'($urandom);
        ld_data   = $urandom;
        #1;
        exp_fr = !ld_we && (!m_valid || rsp_ready);
        check("rand_fetch_ready", fetch_ready, exp_fr);
        check("rand_ld_ready", ld_ready, 1);
        if (fetch_req && exp_fr) begin
          idx     = longint'(fetch_pc) / 4;
          m_fa    = (fetch_pc % 4) != 0;
          m_fr    = idx >= DEPTH;
          m_instr = (m_fa || m_fr) ? NOP : m_mem[idx];
          m_valid = 1'b1;
        end else if (rsp_ready) begin
          m_valid = 1'b0;
        end
        if (ld_we) m_mem[ld_addr] = ld_data;
        tick();
        check("rand_valid", rsp_valid, m_valid);
        if (m_valid) begin
          check("rand_instr", rsp_instr, m_instr);
          check("rand_align", rsp_fault_align, m_fa);
          check("rand_range", rsp_fault_range, m_fr);
        end
      end
    end
    fetch_req = 1'b0;
    ld_we     = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
